// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin pop scheduler for a 4-queue FIFO bank: grants a non-empty
// queue in rotating order for up to its weight in consecutive pops, honouring backpressure.
module wrr_pop_scheduler #(
   parameter int unsigned WW = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [3:0]      empty,
   input  logic [4*WW-1:0] weights,
   input  logic            down_full,
   output logic [3:0]      pop,
   output logic            valid,
   output logic [1:0]      pop_id,
   output logic            busy
);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t        state;
   logic [1:0]    ptr;
   logic [1:0]    cur;
   logic [WW-1:0] cnt;
   logic [WW-1:0] wcur;

   logic [1:0]    next_q;
   logic [WW-1:0] w_sel;
   logic [WW-1:0] w_eff;
   logic          pop_any;

   // Rotating search starting just after the last served queue.
   always_comb begin
      logic [1:0] cand;
      logic       found;
      next_q = ptr;
      found  = 1'b0;
      for (int unsigned k = 1; k <= 4; k++) begin
         cand = ptr + k[1:0];
         if (!found && !empty[cand]) begin
            next_q = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      w_sel = weights[next_q*WW +: WW];
      w_eff = (w_sel == '0) ? WW'(1) : w_sel;
   end

   always_comb begin
      pop = '0;
      if (state == SERVE && !empty[cur] && !down_full)
         pop[cur] = 1'b1;
   end

   assign pop_any = |pop;
   assign busy    = (state == SERVE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         ptr    <= 2'd3;
         cur    <= '0;
         cnt    <= '0;
         wcur   <= '0;
         valid  <= 1'b0;
         pop_id <= '0;
      end else begin
         valid <= pop_any;
         if (pop_any)
            pop_id <= cur;
         case (state)
            IDLE: begin
               if (empty != 4'hF) begin
                  cur   <= next_q;
                  wcur  <= w_eff;
                  cnt   <= '0;
                  state <= SERVE;
               end
            end
            SERVE: begin
               if (empty[cur]) begin
                  ptr   <= cur;
                  state <= IDLE;
               end else if (!down_full) begin
                  cnt <= cnt + WW'(1);
                  if (cnt + WW'(1) == wcur) begin
                     ptr   <= cur;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// Self-checking bench for wrr_pop_scheduler: table vectors, directed corner cases,
// and random stimulus against a burst-level reference model.
module tb_wrr_pop_scheduler;

   localparam int unsigned WW = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [3:0]      empty;
   logic [4*WW-1:0] weights;
   logic            down_full;
   logic [3:0]      pop;
   logic            valid;
   logic [1:0]      pop_id;
   logic            busy;

   int total = 0;
   int bad   = 0;
   int pop_cnt [4];

   // Reference model: serving flag, granted queue, words left in the burst.
   bit       m_serving;
   int       m_q;
   int       m_left;
   int       m_last;
   bit       m_valid;
   int       m_id;

   typedef struct {
      logic [3:0]      e;
      logic [4*WW-1:0] w;
      logic            d;
      logic [3:0]      p;
      logic            v;
      logic [1:0]      id;
      logic            b;
   } vec_t;

   vec_t tbl [11];

   wrr_pop_scheduler #(.WW(WW)) dut (
      .clk       (clk),
      .reset     (reset),
      .empty     (empty),
      .weights   (weights),
      .down_full (down_full),
      .pop       (pop),
      .valid     (valid),
      .pop_id    (pop_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] m_pop();
      logic [3:0] p = '0;
      if (m_serving && !empty[m_q] && !down_full) p[m_q] = 1'b1;
      return p;
   endfunction

   task automatic model_reset();
      m_serving = 0; m_q = 0; m_left = 0; m_last = 3; m_valid = 0; m_id = 0;
   endtask

   task automatic model_update(input logic [3:0] e, input logic [4*WW-1:0] w, input logic d);
      bit popped;
      popped  = m_serving && !e[m_q] && !d;
      m_valid = popped;
      if (popped) m_id = m_q;
      if (!m_serving) begin
         if (e != 4'hF) begin
            for (int k = 1; k <= 4; k++) begin
               if (!e[(m_last + k) % 4]) begin
                  m_q = (m_last + k) % 4;
                  break;
               end
            end
            m_left    = int'(w[m_q*WW +: WW]);
            if (m_left == 0) m_left = 1;
            m_serving = 1;
         end
      end else if (popped) begin
         m_left--;
         if (m_left == 0) begin m_last = m_q; m_serving = 0; end
      end else if (e[m_q]) begin
         m_last = m_q; m_serving = 0;
      end
   endtask

   task automatic drive(input logic [3:0] e, input logic [4*WW-1:0] w, input logic d);
      empty = e; weights = w; down_full = d;
      #2;
   endtask

   task automatic check_model();
      chk("pop", 16'(pop), 16'(m_pop()));
      chk("busy", 16'(busy), 16'(m_serving));
      chk("valid", 16'(valid), 16'(m_valid));
      chk("pop_id", 16'(pop_id), 16'(m_id));
   endtask

   task automatic advance();
      for (int i = 0; i < 4; i++) if (pop[i]) pop_cnt[i]++;
      @(posedge clk);
      model_update(empty, weights, down_full);
      #1;
   endtask

   task automatic step(input logic [3:0] e, input logic [4*WW-1:0] w, input logic d);
      drive(e, w, d);
      check_model();
      advance();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      #1;
      chk("rst_pop", 16'(pop), 16'h0);
      chk("rst_valid", 16'(valid), 16'h0);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_id", 16'(pop_id), 16'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) pop_cnt[i] = 0;
   endtask

   localparam logic [4*WW-1:0] W_ONES = {3'd1, 3'd1, 3'd1, 3'd1};
   localparam logic [4*WW-1:0] W_T3   = {3'd1, 3'd1, 3'd2, 3'd3};
   localparam logic [4*WW-1:0] W_T4   = {3'd1, 3'd1, 3'd1, 3'd3};
   localparam logic [4*WW-1:0] W_T5   = {3'd1, 3'd4, 3'd1, 3'd1};

   initial begin
      tbl[0]  = '{4'h0, W_ONES, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
      tbl[1]  = '{4'h0, W_ONES, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1};
      tbl[2]  = '{4'h0, W_ONES, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0};
      tbl[3]  = '{4'h0, W_ONES, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b1};
      tbl[4]  = '{4'h0, W_ONES, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0};
      tbl[5]  = '{4'h0, W_ONES, 1'b0, 4'b0100, 1'b0, 2'd1, 1'b1};
      tbl[6]  = '{4'h0, W_ONES, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0};
      tbl[7]  = '{4'h0, W_ONES, 1'b0, 4'b1000, 1'b0, 2'd2, 1'b1};
      tbl[8]  = '{4'h0, W_ONES, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0};
      tbl[9]  = '{4'h0, W_ONES, 1'b0, 4'b0001, 1'b0, 2'd3, 1'b1};
      tbl[10] = '{4'h0, W_ONES, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0};

      empty = 4'hF; weights = W_ONES; down_full = 1'b0;

      // All empty after reset: nothing happens.
      do_reset();
      for (int i = 0; i < 10; i++) step(4'hF, W_ONES, 1'b0);

      // Weight-1 rotation, table driven.
      do_reset();
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].e, tbl[i].w, tbl[i].d);
         chk("tbl_pop", 16'(pop), 16'(tbl[i].p));
         chk("tbl_valid", 16'(valid), 16'(tbl[i].v));
         chk("tbl_id", 16'(pop_id), 16'(tbl[i].id));
         chk("tbl_busy", 16'(busy), 16'(tbl[i].b));
         advance();
      end

      // Mixed weights: q0 x3, gap, q1 x2.
      do_reset();
      for (int i = 0; i < 8; i++) step(4'h0, W_T3, 1'b0);
      chk("t3_q0_pops", 16'(pop_cnt[0]), 16'd3);
      chk("t3_q1_pops", 16'(pop_cnt[1]), 16'd2);

      // Backpressure holds the burst count.
      do_reset();
      step(4'h0, W_T4, 1'b0);
      step(4'h0, W_T4, 1'b0);
      step(4'h0, W_T4, 1'b1);
      step(4'h0, W_T4, 1'b1);
      step(4'h0, W_T4, 1'b0);
      step(4'h0, W_T4, 1'b0);
      step(4'h0, W_T4, 1'b0);
      drive(4'h0, W_T4, 1'b0);
      chk("t4_next_q1", 16'(pop), 16'b0010);
      advance();
      chk("t4_q0_pops", 16'(pop_cnt[0]), 16'd3);

      // Burst forfeited when the queue drains, then single-queue regrants.
      do_reset();
      step(4'b0011, W_T5, 1'b0);
      step(4'b0011, W_T5, 1'b0);
      step(4'b0111, W_T5, 1'b0);
      step(4'b0111, W_T5, 1'b0);
      drive(4'b0111, W_T5, 1'b0);
      chk("t5_grant_q3", 16'(pop), 16'b1000);
      advance();
      chk("t5_q2_pops", 16'(pop_cnt[2]), 16'd1);
      for (int i = 0; i < 8; i++) step(4'b1101, W_T5, 1'b0);
      chk("t5_q1_pops", 16'(pop_cnt[1]), 16'd4);

      // Reset in the middle of a q2 burst.
      do_reset();
      step(4'b1011, W_T5, 1'b0);
      step(4'b1011, W_T5, 1'b0);
      drive(4'b1011, W_T5, 1'b0);
      chk("t6_pre_pop", 16'(pop), 16'b0100);
      chk("t6_pre_valid", 16'(valid), 16'h1);
      do_reset();
      step(4'h0, W_T5, 1'b0);
      drive(4'h0, W_T5, 1'b0);
      chk("t6_first_q0", 16'(pop), 16'b0001);
      advance();

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic [3:0]      e;
         logic [4*WW-1:0] w;
         logic            d;
         e = 4'($urandom) & 4'($urandom);
         w = (4*WW)'($urandom);
         d = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) == 0) begin
            drive(e, w, d);
            do_reset();
         end
         step(e, w, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
